wdog_period_ctrl: RTL and testbench
===================================

Name: wdog_period_ctrl

Overview:
Host-communication watchdog for the FPGA V3 DQLA build. It sits beside the DQLA block on the shared read/write bus and produces wdog_timeout, wdog_period_status and wdog_period_led. It arms from the watchdog period register, refreshes on any host write activity and latches a timeout when the host falls silent.

Parameters:
WDOG_ADDR, 16'h0003, board-space address of the watchdog period register.
TICK_LOG2, 8, prescaler width; one tick = 2^TICK_LOG2 sysclk cycles (≈5.2 µs at 49.152 MHz).
PERIOD_W, 16, width of the period register and the tick counter.

Ports:
sysclk  in  1  system clock, 49.152 MHz
reset  in  1  synchronous, active-high reset
reg_waddr  in  16  write address
reg_wdata  in  32  write data
reg_wen  in  1  quadlet write strobe
blk_wen  in  1  block write strobe
rt_wen  in  1  real-time write strobe
reg_raddr  in  16  read address
wdog_rdata  out  32  registered read data: {timeout, 14'b0, led_sel, period}
wdog_clear  in  1  clear pulse (e.g. on power-up)
wdog_timeout  out  1  latched timeout flag
wdog_period_status  out  3  period magnitude code
wdog_period_led  out  1  1 -> the external LED shows wdog_period_status

Behaviour:
- Reset: period=0, cnt=0, prescaler=0, state=IDLE. All outputs are 0.
- Period write: fires when reg_wen=1 and reg_waddr==WDOG_ADDR.
  - period <= reg_wdata[15:0]; led_sel <= reg_wdata[16].
  - cnt <= 0; timeout is cleared.
  - Next state is ARMED if the new period is non-zero, IDLE if it is zero.
- Refresh: any reg_wen, blk_wen or rt_wen clears cnt. A refresh never clears a latched timeout.
- Prescaler: free-running TICK_LOG2-bit counter. tick=1 on the cycle it wraps to 0.
- FSM:
  - IDLE: cnt held at 0; no ticks are counted.
  - ARMED: on tick without refresh, cnt <= cnt+1. When cnt+1 == period, go to TIMEOUT and set wdog_timeout on the next edge.
  - TIMEOUT: wdog_timeout=1 and cnt is frozen. Leave on wdog_clear (go to ARMED if period≠0, else IDLE) or on a period write (rules above).
- Simultaneous events, in priority order: reset > period write > wdog_clear > refresh > tick. A refresh in the same cycle as the expiring tick prevents the timeout.
- cnt never wraps: it saturates at period, and the equality compare guarantees this.
- period=1: the timeout occurs at the first tick not coincident with a refresh.
- Period-to-timeout latency: period ticks after the last refresh, ±1 tick of prescaler phase, plus one sysclk.
- wdog_period_status is a registered function of period, updated one cycle after the write:
  - 0 → 0
  - ≤10 → 1
  - ≤20 → 2
  - ≤50 → 3
  - ≤100 → 4
  - ≤200 → 5
  - ≤500 → 6
  - else → 7
- wdog_period_led = led_sel & (state≠IDLE).
- Readback: wdog_rdata is registered (1-cycle latency). It is non-zero only when the previous-cycle reg_raddr==WDOG_ADDR; otherwise it is 0 so it can be OR-merged onto the bus.

Optional Feature:
WDOG_TIMEOUT_CAPTURE_EN:
- Defined: adds input timestamp[31:0] and output wdog_ts[31:0]. wdog_ts latches timestamp on the cycle that enters TIMEOUT. It holds until the next entry into TIMEOUT and resets to 0.
- Undefined: neither port exists and behaviour is otherwise identical.

Decomposition:
- Package wdog_pkg:
  - state enum (IDLE, ARMED, TIMEOUT)
  - WDOG_ADDR default
  - status threshold constants 10/20/50/100/200/500
  - read-data field offsets
- One sub-module, wdog_tick_gen: the prescaler, with TICK_LOG2 parameter and a tick output.
- The FSM, counter and status encoding stay in wdog_period_ctrl.

Test Plan:
1. Reset, then write period=4 with no refreshes → wdog_timeout rises 4 ticks (1024 ±256 cycles) later; status=1.
2. period=4, rt_wen pulse every 600 cycles for 20000 cycles → wdog_timeout stays 0 throughout.
3. In TIMEOUT, pulse blk_wen → timeout stays 1; then pulse wdog_clear → timeout falls and the FSM is ARMED; a second timeout follows after 4 ticks.
4. Write period=300 with bit16=1 → status=6 and wdog_period_led=1; write period=0 → status=0, led=0, IDLE, and no timeout ever.
5. Force a refresh on the exact expiring tick (period=1) → no timeout; read WDOG_ADDR → wdog_rdata=32'h0001_0001 one cycle later.
6. Assert reset in TIMEOUT with period=8 → all outputs 0 next cycle. With WDOG_TIMEOUT_CAPTURE_EN, wdog_ts equals the timestamp value present at the TIMEOUT entry cycle.

Source files
------------

// File: rtl/wdog_period_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wdog_pkg
// Shared definitions for the host-communication watchdog (wdog_period_ctrl):
//   - watchdog FSM state encoding
//   - default board-space address of the watchdog period register
//   - period-magnitude thresholds used by wdog_period_status
//   - bit positions of the fields in the read-back word
// ---------------------------------------------------------------------------
package wdog_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_TIMEOUT = 2'd2
   } wdog_state_t;

   localparam logic [15:0] WDOG_ADDR_DEF = 16'h0003;

   // Upper bounds (inclusive) of status codes 1..6; anything larger is code 7.
   localparam logic [31:0] STATUS_TH1 = 32'd10;
   localparam logic [31:0] STATUS_TH2 = 32'd20;
   localparam logic [31:0] STATUS_TH3 = 32'd50;
   localparam logic [31:0] STATUS_TH4 = 32'd100;
   localparam logic [31:0] STATUS_TH5 = 32'd200;
   localparam logic [31:0] STATUS_TH6 = 32'd500;

   // Read-back word layout: {timeout, 14'b0, led_sel, period}
   localparam int RD_PERIOD_LSB  = 0;
   localparam int RD_LED_BIT     = 16;
   localparam int RD_TIMEOUT_BIT = 31;

endpackage

// File: rtl/wdog_period_ctrl_if.sv
// ---------------------------------------------------------------------------
// wdog_period_ctrl_if
// Shared host read/write bus as seen by the watchdog.
//   reg_waddr[15:0]  write address
//   reg_wdata[31:0]  write data
//   reg_wen          quadlet write strobe
//   blk_wen          block write strobe
//   rt_wen           real-time write strobe
//   reg_raddr[15:0]  read address
//   wdog_rdata[31:0] registered read data (zero unless the watchdog was addressed)
// master: the host side; slave: the watchdog.
// ---------------------------------------------------------------------------
interface wdog_period_ctrl_if;
   logic [15:0] reg_waddr;
   logic [31:0] reg_wdata;
   logic        reg_wen;
   logic        blk_wen;
   logic        rt_wen;
   logic [15:0] reg_raddr;
   logic [31:0] wdog_rdata;

   modport master (
      output reg_waddr, reg_wdata, reg_wen, blk_wen, rt_wen, reg_raddr,
      input  wdog_rdata
   );

   modport slave (
      input  reg_waddr, reg_wdata, reg_wen, blk_wen, rt_wen, reg_raddr,
      output wdog_rdata
   );
endinterface

// File: rtl/wdog_period_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// wdog_tick_gen
// Free-running prescaler for the watchdog. One tick every 2^TICK_LOG2 sysclk
// cycles; tick is high during the cycle whose edge wraps the count to 0.
// Ports:
//   sysclk  system clock
//   reset   synchronous, active-high reset (count returns to 0)
//   tick    one-cycle pulse per prescaler period
// ---------------------------------------------------------------------------
module wdog_tick_gen #(
   parameter int TICK_LOG2 = 8
) (
   input  logic sysclk,
   input  logic reset,
   output logic tick
);

   logic [TICK_LOG2-1:0] presc;

   always_ff @(posedge sysclk) begin
      if (reset) presc <= '0;
      else       presc <= presc + 1'b1;
   end

   assign tick = &presc;

endmodule

// File: rtl/wdog_period_ctrl.sv
// ---------------------------------------------------------------------------
// wdog_period_ctrl
// Host-communication watchdog. Armed by a write to the period register, kept
// alive by any host write activity, and latches wdog_timeout once the host has
// been silent for `period` prescaler ticks.
// Ports:
//   sysclk              system clock
//   reset               synchronous, active-high reset
//   bus (slave)         shared host bus: write strobes/address/data, read
//                       address and the registered read data wdog_rdata
//   wdog_clear          clear pulse; drops a latched timeout and re-arms
//   wdog_timeout        latched timeout flag
//   wdog_period_status  3-bit magnitude code of the programmed period
//   wdog_period_led     1 -> external LED shows wdog_period_status
// Optional build macro WDOG_TIMEOUT_CAPTURE_EN adds:
//   timestamp[31:0]     free-running time base (input)
//   wdog_ts[31:0]       timestamp captured on entry into TIMEOUT
// ---------------------------------------------------------------------------
module wdog_period_ctrl
   import wdog_pkg::*;
#(
   parameter logic [15:0] WDOG_ADDR = WDOG_ADDR_DEF,
   parameter int          TICK_LOG2 = 8,
   parameter int          PERIOD_W  = 16
) (
   input  logic                sysclk,
   input  logic                reset,
   wdog_period_ctrl_if.slave   bus,
   input  logic                wdog_clear,
   output logic                wdog_timeout,
   output logic [2:0]          wdog_period_status,
   output logic                wdog_period_led
`ifdef WDOG_TIMEOUT_CAPTURE_EN
   ,
   input  logic [31:0]         timestamp,
   output logic [31:0]         wdog_ts
`endif
);

   wdog_state_t         state, state_nx;
   logic [PERIOD_W-1:0] period, cnt, cnt_nx;
   logic                led_sel;
   logic [2:0]          status;
   logic [31:0]         rdata, rd_word;
   logic                tick, period_wr, refresh;

   function automatic logic [2:0] period_code(input logic [PERIOD_W-1:0] p);
      logic [31:0] v;
      v = 32'(p);
      if      (v == 32'd0)       period_code = 3'd0;
      else if (v <= STATUS_TH1)  period_code = 3'd1;
      else if (v <= STATUS_TH2)  period_code = 3'd2;
      else if (v <= STATUS_TH3)  period_code = 3'd3;
      else if (v <= STATUS_TH4)  period_code = 3'd4;
      else if (v <= STATUS_TH5)  period_code = 3'd5;
      else if (v <= STATUS_TH6)  period_code = 3'd6;
      else                       period_code = 3'd7;
   endfunction

   wdog_tick_gen #(.TICK_LOG2(TICK_LOG2)) u_tick (
      .sysclk (sysclk),
      .reset  (reset),
      .tick   (tick)
   );

   assign period_wr = bus.reg_wen && (bus.reg_waddr == WDOG_ADDR);
   assign refresh   = bus.reg_wen | bus.blk_wen | bus.rt_wen;

   // Priority: period write > clear > refresh > tick. Entering ARMED or IDLE
   // always zeroes cnt, so cnt only ever climbs from 0 and the equality
   // compare stops it at period.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (period_wr) begin
         cnt_nx   = '0;
         state_nx = (bus.reg_wdata[PERIOD_W-1:0] != '0) ? ST_ARMED : ST_IDLE;
      end else if (wdog_clear) begin
         cnt_nx   = '0;
         state_nx = (period != '0) ? ST_ARMED : ST_IDLE;
      end else if (refresh) begin
         // cnt stays frozen while a timeout is latched
         if (state != ST_TIMEOUT) cnt_nx = '0;
      end else if (tick && (state == ST_ARMED)) begin
         cnt_nx = cnt + 1'b1;
         if (cnt_nx == period) state_nx = ST_TIMEOUT;
      end
   end

   always_comb begin
      rd_word                               = '0;
      rd_word[RD_TIMEOUT_BIT]               = (state == ST_TIMEOUT);
      rd_word[RD_LED_BIT]                   = led_sel;
      rd_word[RD_PERIOD_LSB +: PERIOD_W]    = period;
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         period  <= '0;
         led_sel <= 1'b0;
         status  <= 3'd0;
         rdata   <= '0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         if (period_wr) begin
            period  <= bus.reg_wdata[PERIOD_W-1:0];
            led_sel <= bus.reg_wdata[RD_LED_BIT];
         end
         // encoded from the already-registered period: lags the write by a cycle
         status <= period_code(period);
         // zero when not addressed so several blocks can be OR-merged
         rdata  <= (bus.reg_raddr == WDOG_ADDR) ? rd_word : '0;
      end
   end

`ifdef WDOG_TIMEOUT_CAPTURE_EN
   always_ff @(posedge sysclk) begin
      if (reset)
         wdog_ts <= '0;
      else if ((state_nx == ST_TIMEOUT) && (state != ST_TIMEOUT))
         wdog_ts <= timestamp;
   end
`endif

   assign wdog_timeout       = (state == ST_TIMEOUT);
   assign wdog_period_status = status;
   assign wdog_period_led    = led_sel & (state != ST_IDLE);
   assign bus.wdog_rdata     = rdata;

   logic unused_wdata;
   assign unused_wdata = ^bus.reg_wdata[31:RD_LED_BIT+1];

endmodule

// File: tb/tb_wdog_period_ctrl.sv
module tb_wdog_period_ctrl;

   logic        sysclk = 1'b0;
   logic        reset  = 1'b1;
   logic        wdog_clear = 1'b0;
   logic        wdog_timeout;
   logic [2:0]  wdog_period_status;
   logic        wdog_period_led;
`ifdef WDOG_TIMEOUT_CAPTURE_EN
   logic [31:0] ts_cnt = 32'd0;
   logic [31:0] wdog_ts;
   logic [31:0] m_ts;
`endif

   wdog_period_ctrl_if bus();

   wdog_period_ctrl dut (
      .sysclk             (sysclk),
      .reset              (reset),
      .bus                (bus),
      .wdog_clear         (wdog_clear),
      .wdog_timeout       (wdog_timeout),
      .wdog_period_status (wdog_period_status),
      .wdog_period_led    (wdog_period_led)
`ifdef WDOG_TIMEOUT_CAPTURE_EN
      ,
      .timestamp          (ts_cnt),
      .wdog_ts            (wdog_ts)
`endif
   );

   always #5 sysclk = ~sysclk;

`ifdef WDOG_TIMEOUT_CAPTURE_EN
   always @(posedge sysclk) ts_cnt <= ts_cnt + 32'd1;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Status code straight from the threshold table.
   function automatic logic [2:0] exp_code(input int p);
      int th [6];
      th = '{10, 20, 50, 100, 200, 500};
      if (p == 0) return 3'd0;
      for (int i = 0; i < 6; i++)
         if (p <= th[i]) return 3'(i + 1);
      return 3'd7;
   endfunction

   // ---------------- behavioural reference model ----------------
   // The watchdog is "silent-tick counting": ticks seen since the last refresh,
   // write or clear; once that reaches the period the timeout latches.
   int unsigned m_phase;     // sysclk edges since reset released
   logic [15:0] m_period;
   logic        m_led;
   logic        m_to;
   int          m_silent;
   logic [2:0]  m_status;
   logic [31:0] m_rdata;
   bit          m_tick, m_refresh;

   always @(posedge sysclk) begin
      if (reset) begin
         m_phase = 0; m_period = 16'd0; m_led = 1'b0; m_to = 1'b0;
         m_silent = 0; m_status = 3'd0; m_rdata = 32'd0;
`ifdef WDOG_TIMEOUT_CAPTURE_EN
         m_ts = 32'd0;
`endif
      end else begin
         m_tick    = (m_phase % 256) == 255;
         m_phase++;
         m_rdata   = (bus.reg_raddr == 16'h0003) ? {m_to, 14'b0, m_led, m_period} : 32'd0;
         m_status  = exp_code(int'(m_period));
         m_refresh = bus.reg_wen | bus.blk_wen | bus.rt_wen;
         if (bus.reg_wen && bus.reg_waddr == 16'h0003) begin
            m_period = bus.reg_wdata[15:0];
            m_led    = bus.reg_wdata[16];
            m_silent = 0;
            m_to     = 1'b0;
         end else if (wdog_clear) begin
            m_silent = 0;
            m_to     = 1'b0;
         end else if (m_refresh) begin
            m_silent = 0;
         end else if (m_tick && m_period != 16'd0 && !m_to) begin
            m_silent++;
            if (m_silent >= int'(m_period)) begin
               m_to = 1'b1;
`ifdef WDOG_TIMEOUT_CAPTURE_EN
               m_ts = ts_cnt;
`endif
            end
         end
      end
   end

   always @(negedge sysclk) begin
      if (chk_en) begin
         check("timeout", {31'd0, wdog_timeout}, {31'd0, m_to});
         check("status", {29'd0, wdog_period_status}, {29'd0, m_status});
         check("led", {31'd0, wdog_period_led}, {31'd0, m_led & (m_period != 16'd0)});
         check("rdata", bus.wdog_rdata, m_rdata);
`ifdef WDOG_TIMEOUT_CAPTURE_EN
         check("wdog_ts", wdog_ts, m_ts);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic idle_bus();
      bus.reg_waddr = 16'h0; bus.reg_wdata = 32'h0; bus.reg_wen = 1'b0;
      bus.blk_wen = 1'b0; bus.rt_wen = 1'b0; bus.reg_raddr = 16'h0;
      wdog_clear = 1'b0;
   endtask

   task automatic wr_period(input logic [31:0] d);
      bus.reg_waddr = 16'h0003; bus.reg_wdata = d; bus.reg_wen = 1'b1;
      step(1);
      bus.reg_wen = 1'b0; bus.reg_waddr = 16'h0; bus.reg_wdata = 32'h0;
   endtask

   task automatic wait_timeout(input int maxc, output int n);
      n = 0;
      while (!wdog_timeout && n < maxc) begin
         step(1);
         n++;
      end
   endtask

   int n, hits;

   initial begin
      idle_bus();
      reset = 1'b1;
      step(2);
      chk_en = 1'b1;
      check("rst_timeout", {31'd0, wdog_timeout}, 32'd0);
      check("rst_status", {29'd0, wdog_period_status}, 32'd0);
      check("rst_led", {31'd0, wdog_period_led}, 32'd0);
      check("rst_rdata", bus.wdog_rdata, 32'd0);
      reset = 1'b0;
      step(3);

      // 1: period=4, host silent
      wr_period(32'd4);
      step(1);
      check("p4_status", {29'd0, wdog_period_status}, 32'd1);
      wait_timeout(2000, n);
      n = n + 1;
      check("p4_timeout_seen", {31'd0, wdog_timeout}, 32'd1);
      check("p4_latency_in_window", {31'd0, (n >= 768 && n <= 1280)}, 32'd1);

      // 3: refresh does not clear a latched timeout; clear does
      bus.blk_wen = 1'b1; step(1); bus.blk_wen = 1'b0;
      step(1);
      check("blk_keeps_timeout", {31'd0, wdog_timeout}, 32'd1);
      wdog_clear = 1'b1; step(1); wdog_clear = 1'b0;
      check("clear_drops_timeout", {31'd0, wdog_timeout}, 32'd0);
      wait_timeout(2000, n);
      check("rearm_timeout_seen", {31'd0, wdog_timeout}, 32'd1);
      check("rearm_latency_in_window", {31'd0, (n >= 767 && n <= 1280)}, 32'd1);

      // 2: periodic rt_wen keeps it alive
      wr_period(32'd4);
      hits = 0;
      for (int i = 0; i < 20000; i++) begin
         bus.rt_wen = (i % 600 == 0);
         step(1);
         if (wdog_timeout) hits++;
      end
      bus.rt_wen = 1'b0;
      check("rt_refresh_no_timeout", hits, 0);

      // 4: large period with LED, then disable
      wr_period(32'h0001_012C);
      step(1);
      check("p300_status", {29'd0, wdog_period_status}, 32'd6);
      check("p300_led", {31'd0, wdog_period_led}, 32'd1);
      wr_period(32'h0000_0000);
      step(1);
      check("p0_status", {29'd0, wdog_period_status}, 32'd0);
      check("p0_led", {31'd0, wdog_period_led}, 32'd0);
      hits = 0;
      for (int i = 0; i < 1500; i++) begin
         step(1);
         if (wdog_timeout) hits++;
      end
      check("p0_no_timeout", hits, 0);

      // 5: period=1, refresh lands exactly on the expiring tick
      n = 0;
      while ((m_phase % 256) != 254 && n < 600) begin
         step(1);
         n++;
      end
      wr_period(32'h0001_0001);
      bus.rt_wen = 1'b1; step(1); bus.rt_wen = 1'b0;
      check("refresh_on_tick_no_timeout", {31'd0, wdog_timeout}, 32'd0);
      bus.reg_raddr = 16'h0003; step(1); bus.reg_raddr = 16'h0;
      check("readback", bus.wdog_rdata, 32'h0001_0001);
      step(1);
      check("readback_unaddressed", bus.wdog_rdata, 32'd0);

      // 6: reset while timed out
      wr_period(32'd8);
      wait_timeout(9 * 256 + 20, n);
      check("p8_timeout_seen", {31'd0, wdog_timeout}, 32'd1);
      bus.reg_raddr = 16'h0003;
      reset = 1'b1; step(1);
      check("rst2_timeout", {31'd0, wdog_timeout}, 32'd0);
      check("rst2_status", {29'd0, wdog_period_status}, 32'd0);
      check("rst2_led", {31'd0, wdog_period_led}, 32'd0);
      check("rst2_rdata", bus.wdog_rdata, 32'd0);
`ifdef WDOG_TIMEOUT_CAPTURE_EN
      check("rst2_ts", wdog_ts, 32'd0);
`endif
      reset = 1'b0;
      bus.reg_raddr = 16'h0;
      step(2);

      // random traffic against the model
      for (int i = 0; i < 12000; i++) begin
         idle_bus();
         if ($urandom_range(0, 999) < 2) begin
            bus.reg_wen = 1'b1; bus.reg_waddr = 16'h0003;
            bus.reg_wdata = {15'd0, 1'($urandom_range(0, 1)),
                             ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 700))
                                                         : 16'($urandom_range(0, 5))};
         end else if ($urandom_range(0, 999) < 2) begin
            bus.reg_wen = 1'b1; bus.reg_waddr = 16'($urandom_range(4, 100));
            bus.reg_wdata = $urandom;
         end
         bus.blk_wen   = ($urandom_range(0, 999) < 1);
         bus.rt_wen    = ($urandom_range(0, 999) < 1);
         wdog_clear    = ($urandom_range(0, 999) < 2);
         bus.reg_raddr = ($urandom_range(0, 1) == 1) ? 16'h0003 : 16'($urandom_range(0, 15));
         reset         = ($urandom_range(0, 1999) == 0);
         step(1);
      end
      idle_bus();
      reset = 1'b0;
      step(2);
      chk_en = 1'b0;
      step(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
